pd_hash_reassembly: RTL and testbench

// - Receive side of the PD 20-word packet link. Takes the 16-bit word stream from the link RX
//   and rebuilds one packet: PID, transmit-empty flag and the 18-word hash+nonce block.
// - Word order: W0={SYNC 8'h54,PID}, W1=metadata (16'd0/16'd1), W2..W19=hash[17]..hash[0].
// - Presents the completed packet to the miner core with a valid/ack handshake.

---
 rtl/pd_pkg.sv | 20 ++
 rtl/pd_rx_timeout_timer.sv | 37 +++
 rtl/pd_hash_reassembly.sv | 181 ++++++++++++++++++
 tb/tb_pd_hash_reassembly.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pd_pkg.sv
// Shared definitions for the PD 20-word packet link (transmit serializer and receive reassembly).
package pd_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'h54;
    localparam int         PKT_WORDS  = 20;
    localparam int         HASH_WORDS = 18;

    typedef logic [15:0]                 pd_word_t;
    typedef pd_word_t [HASH_WORDS-1:0]   pd_hash_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        META = 2'd1,
        HASH = 2'd2
    } pd_rx_state_t;

    // Counter value of the final hash word (W19); HASH exits here, so the counter never hits 18.
    localparam logic [4:0] LAST_HASH_CNT = 5'(HASH_WORDS - 1);

endpackage

// File: rtl/pd_rx_timeout_timer.sv
// Idle-cycle counter for the PD receive path: counts enabled cycles since the last clear and
// flags expiry on the cycle the count would reach TIMEOUT_CYCLES.
module pd_rx_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_IDLE = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LAST_IDLE)) begin
            count_d = count_q + 1'b1;
        end
    end

    assign expire = enable && !clear && (count_q == LAST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pd_hash_reassembly.sv
// PD link receive side: rebuilds {PID, transmit-empty, 18-word hash} from the RX word stream and
// hands it to the miner core via valid/ack. Optional inter-word timeout under PD_RX_TIMEOUT_EN.
module pd_hash_reassembly
    import pd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] rx_data,
    input  logic        rx_valid,
    input  logic        hash_ack,
    output pd_hash_t    hash,
    output logic [7:0]  pid,
    output logic        transmit_empty,
    output logic        hash_valid,
    output logic        busy,
    output logic        pkt_error,
    output logic        overrun
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("pd_hash_reassembly: TIMEOUT_CYCLES must be at least 1");
    end

    pd_rx_state_t state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;

    // Shadow holds W2..W18 only; W19 goes straight from rx_data into the held hash on commit.
    pd_word_t [HASH_WORDS-1:1] shadow_q, shadow_d;
    logic [7:0]   shadow_pid_q, shadow_pid_d;
    logic         shadow_flag_q, shadow_flag_d;

    pd_hash_t     hash_q, hash_d;
    logic [7:0]   pid_q, pid_d;
    logic         te_q, te_d;
    logic         hv_q, hv_d;
    logic         perr_q, perr_d;
    logic         ovr_q, ovr_d;

    logic         sync_hit;
    logic         meta_ok;
    logic         meta_bad;
    logic         commit;
    logic         timeout_expire;

    assign sync_hit = rx_valid && (rx_data[15:8] == SYNC_BYTE);
    assign meta_ok  = (rx_data == 16'd0) || (rx_data == 16'd1);
    assign meta_bad = (state_q == META) && rx_valid && !meta_ok;
    assign commit   = (state_q == HASH) && rx_valid && (cnt_q == LAST_HASH_CNT);

`ifdef PD_RX_TIMEOUT_EN
    pd_rx_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (rx_valid || (state_q == IDLE)),
        .enable (state_q != IDLE),
        .expire (timeout_expire)
    );
`else
    assign timeout_expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (sync_hit) begin
                    state_d = META;
                end
            end
            META: begin
                if (rx_valid) begin
                    state_d = meta_ok ? HASH : IDLE;
                end else if (timeout_expire) begin
                    state_d = IDLE;
                end
            end
            HASH: begin
                if (commit) begin
                    state_d = IDLE;
                end else if (timeout_expire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d         = cnt_q;
        shadow_d      = shadow_q;
        shadow_pid_d  = shadow_pid_q;
        shadow_flag_d = shadow_flag_q;

        if ((state_q == IDLE) && sync_hit) begin
            shadow_pid_d = rx_data[7:0];
        end

        if ((state_q == META) && rx_valid && meta_ok) begin
            shadow_flag_d = rx_data[0];
            cnt_d         = '0;
        end

        if ((state_q == HASH) && rx_valid) begin
            cnt_d = commit ? 5'd0 : cnt_q + 5'd1;
            for (int i = 1; i < HASH_WORDS; i++) begin
                if (cnt_q == 5'(HASH_WORDS - 1 - i)) begin
                    shadow_d[i] = rx_data;
                end
            end
        end
    end

    // Held outputs move only on commit; a new commit beats a same-cycle ack.
    always_comb begin
        hash_d = hash_q;
        pid_d  = pid_q;
        te_d   = te_q;
        hv_d   = hv_q;
        ovr_d  = 1'b0;
        perr_d = meta_bad || timeout_expire;

        if (commit) begin
            hash_d = {shadow_q, rx_data};
            pid_d  = shadow_pid_q;
            te_d   = shadow_flag_q;
            hv_d   = 1'b1;
            ovr_d  = hv_q && !hash_ack;
        end else if (hv_q && hash_ack) begin
            hv_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            shadow_q      <= '0;
            shadow_pid_q  <= '0;
            shadow_flag_q <= 1'b0;
            hash_q        <= '0;
            pid_q         <= '0;
            te_q          <= 1'b0;
            hv_q          <= 1'b0;
            perr_q        <= 1'b0;
            ovr_q         <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            shadow_pid_q  <= shadow_pid_d;
            shadow_flag_q <= shadow_flag_d;
            hash_q        <= hash_d;
            pid_q         <= pid_d;
            te_q          <= te_d;
            hv_q          <= hv_d;
            perr_q        <= perr_d;
            ovr_q         <= ovr_d;
        end
    end

    always_comb begin
        busy           = (state_q != IDLE);
        hash           = hash_q;
        pid            = pid_q;
        transmit_empty = te_q;
        hash_valid     = hv_q;
        pkt_error      = perr_q;
        overrun        = ovr_q;
    end

endmodule

// File: tb/tb_pd_hash_reassembly.sv
// Directed bench for pd_hash_reassembly: clean, junk-prefixed, bad-metadata, handshake,
// gapped, reset and stall scenarios with hand-computed expectations.
module tb_pd_hash_reassembly;

    logic              clk = 1'b0;
    logic              rst;
    logic [15:0]       rx_data;
    logic              rx_valid;
    logic              hash_ack;
    logic [17:0][15:0] hash;
    logic [7:0]        pid;
    logic              transmit_empty;
    logic              hash_valid;
    logic              busy;
    logic              pkt_error;
    logic              overrun;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pd_hash_reassembly #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .hash_ack       (hash_ack),
        .hash           (hash),
        .pid            (pid),
        .transmit_empty (transmit_empty),
        .hash_valid     (hash_valid),
        .busy           (busy),
        .pkt_error      (pkt_error),
        .overrun        (overrun)
    );

    task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected block: W(2+i) = base+i lands in hash[17-i].
    function automatic logic [17:0][15:0] exp_hash(input logic [15:0] base);
        logic [17:0][15:0] h;
        for (int i = 0; i < 18; i++) h[17-i] = base + 16'(i);
        return h;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] w);
        rx_data  = w;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] p, input logic [15:0] meta, input logic [15:0] base,
                            input bit gap, input bit ack_last);
        send({8'h54, p});
        if (gap) tick();
        send(meta);
        for (int i = 0; i < 18; i++) begin
            if (gap) tick();
            if (ack_last && i == 17) hash_ack = 1'b1;
            send(base + 16'(i));
            hash_ack = 1'b0;
        end
    endtask

    task automatic ack_once();
        hash_ack = 1'b1;
        tick();
        hash_ack = 1'b0;
    endtask

    initial begin
        bit saw_err;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        hash_ack = 1'b0;
        tick();
        tick();
        chk("reset hash",       288'(hash), 288'(0));
        chk("reset pid",        288'(pid), 288'(0));
        chk("reset hash_valid", 288'(hash_valid), 288'(0));
        chk("reset busy",       288'(busy), 288'(0));
        chk("reset pkt_error",  288'(pkt_error), 288'(0));
        chk("reset overrun",    288'(overrun), 288'(0));
        rst = 1'b0;
        tick();

        // Clean back-to-back packet
        send_pkt(8'hA5, 16'd1, 16'h1000, 1'b0, 1'b0);
        chk("clean hash[17]",   288'(hash[17]), 288'(16'h1000));
        chk("clean hash[0]",    288'(hash[0]), 288'(16'h1011));
        chk("clean hash",       288'(hash), 288'(exp_hash(16'h1000)));
        chk("clean pid",        288'(pid), 288'(8'hA5));
        chk("clean te",         288'(transmit_empty), 288'(1));
        chk("clean hash_valid", 288'(hash_valid), 288'(1));
        chk("clean overrun",    288'(overrun), 288'(0));
        chk("clean busy",       288'(busy), 288'(0));
        ack_once();
        chk("ack drops valid",  288'(hash_valid), 288'(0));
        chk("ack keeps pid",    288'(pid), 288'(8'hA5));
        ack_once();
        chk("idle ack ignored", 288'(hash_valid), 288'(0));

        // Junk ahead of sync
        send(16'h1234);
        chk("junk1 busy",       288'(busy), 288'(0));
        chk("junk1 pkt_error",  288'(pkt_error), 288'(0));
        send(16'h55A5);
        chk("junk2 busy",       288'(busy), 288'(0));
        chk("junk2 pkt_error",  288'(pkt_error), 288'(0));
        send_pkt(8'h3C, 16'd0, 16'h2000, 1'b0, 1'b0);
        chk("junk pkt hash",    288'(hash), 288'(exp_hash(16'h2000)));
        chk("junk pkt pid",     288'(pid), 288'(8'h3C));
        chk("junk pkt te",      288'(transmit_empty), 288'(0));
        chk("junk pkt valid",   288'(hash_valid), 288'(1));

        // Bad metadata aborts without touching the held packet
        send(16'h5407);
        chk("badmeta busy W0",  288'(busy), 288'(1));
        send(16'd2);
        chk("badmeta pkt_error", 288'(pkt_error), 288'(1));
        chk("badmeta busy",     288'(busy), 288'(0));
        chk("badmeta pid held", 288'(pid), 288'(8'h3C));
        chk("badmeta hash held", 288'(hash), 288'(exp_hash(16'h2000)));
        chk("badmeta valid held", 288'(hash_valid), 288'(1));
        tick();
        chk("badmeta pulse end", 288'(pkt_error), 288'(0));

        // Overwrite of an unacknowledged packet
        send_pkt(8'h08, 16'd1, 16'h3000, 1'b0, 1'b0);
        chk("overrun pulse",    288'(overrun), 288'(1));
        chk("overrun pid",      288'(pid), 288'(8'h08));
        chk("overrun hash",     288'(hash), 288'(exp_hash(16'h3000)));
        chk("overrun valid",    288'(hash_valid), 288'(1));
        tick();
        chk("overrun pulse end", 288'(overrun), 288'(0));
        chk("overrun valid held", 288'(hash_valid), 288'(1));
        ack_once();
        chk("overrun ack",      288'(hash_valid), 288'(0));

        // Commit and ack in the same cycle: new packet wins, no overrun
        send_pkt(8'h11, 16'd0, 16'h7000, 1'b0, 1'b0);
        chk("first of pair ovr", 288'(overrun), 288'(0));
        send_pkt(8'h22, 16'd1, 16'h7100, 1'b0, 1'b1);
        chk("commit+ack valid", 288'(hash_valid), 288'(1));
        chk("commit+ack ovr",   288'(overrun), 288'(0));
        chk("commit+ack pid",   288'(pid), 288'(8'h22));
        ack_once();

        // Gapped packet whose data contains the sync byte
        send_pkt(8'h5A, 16'd1, 16'h5400, 1'b1, 1'b0);
        chk("gap hash",         288'(hash), 288'(exp_hash(16'h5400)));
        chk("gap pid",          288'(pid), 288'(8'h5A));
        chk("gap te",           288'(transmit_empty), 288'(1));
        chk("gap valid",        288'(hash_valid), 288'(1));
        chk("gap overrun",      288'(overrun), 288'(0));

        // Reset after W10 of a new packet
        send(16'h5499);
        send(16'd0);
        for (int i = 0; i < 9; i++) send(16'hBEE0 + 16'(i));
        chk("pre-reset busy",   288'(busy), 288'(1));
        rst = 1'b1;
        #1;
        chk("midrst hash",      288'(hash), 288'(0));
        chk("midrst pid",       288'(pid), 288'(0));
        chk("midrst valid",     288'(hash_valid), 288'(0));
        chk("midrst busy",      288'(busy), 288'(0));
        chk("midrst te",        288'(transmit_empty), 288'(0));
        tick();
        rst = 1'b0;
        tick();
        send_pkt(8'h77, 16'd0, 16'h6000, 1'b0, 1'b0);
        chk("post-rst hash",    288'(hash), 288'(exp_hash(16'h6000)));
        chk("post-rst pid",     288'(pid), 288'(8'h77));
        chk("post-rst valid",   288'(hash_valid), 288'(1));
        chk("post-rst overrun", 288'(overrun), 288'(0));
        ack_once();

        // Stall after W5
        send(16'h5433);
        send(16'd1);
        for (int i = 0; i < 4; i++) send(16'hC000 + 16'(i));
        saw_err = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (pkt_error) saw_err = 1'b1;
        end
`ifdef PD_RX_TIMEOUT_EN
        chk("stall pkt_error",  288'(saw_err), 288'(1));
        chk("stall busy",       288'(busy), 288'(0));
`else
        chk("stall pkt_error",  288'(saw_err), 288'(0));
        chk("stall busy",       288'(busy), 288'(1));
`endif
        chk("stall pid held",   288'(pid), 288'(8'h77));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
